mem_rmw_sweeper: RTL and testbench
==================================

MEM_RMW_SWEEPER -- requirements
Module: mem_rmw_sweeper

Interface
REQ-001 Parameter DATA_W, default 32, memory word width.
REQ-002 Parameter ADDR_W, default 5, memory address width; sweep covers 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a sweep.
REQ-006 incr  input  DATA_W  value added to every word; captured when start is accepted.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  one-cycle pulse when the final write has been issued.
REQ-009 ovf  output  1  sticky; set when any sum exceeds 2**DATA_W-1; cleared on accepted start.
REQ-010 wr_en, port_en_0  output  1 each  write-port controls to the dual-port memory.
REQ-011 addr_in_0  output  ADDR_W  write address; data_in  output  DATA_W  write data.
REQ-012 port_en_1  output  1; addr_in_1  output  ADDR_W  read-port controls.
REQ-013 data_out_1  input  DATA_W  memory read data, valid one cycle after port_en_1/addr_in_1 are presented.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 FSM states: IDLE, READ, DRAIN, DONE.
REQ-016 IDLE: start=1 -> READ; incr latched; ovf cleared; read address counter = 0.
REQ-017 start SHALL be ignored outside IDLE; no queuing.
REQ-018 READ: port_en_1=1, addr_in_1 = counter, counter+1 per cycle; after address 2**ADDR_W-1 -> DRAIN.
REQ-019 Pipeline: read issued in cycle c; data_out_1 sampled in c+1 and sum registered; write presented in c+2 with port_en_0=wr_en=1, addr_in_0 = read address, data_in = sum.
REQ-020 Reads and writes SHALL overlap; a write never targets the address being read in the same cycle.
REQ-021 DRAIN: port_en_1=0; remains 2 cycles to flush pipeline -> DONE.
REQ-022 DONE: done=1 for exactly one cycle -> IDLE.
REQ-023 Timing: with start accepted at edge E, reads occupy cycles 1..2**ADDR_W after E, writes cycles 3..2**ADDR_W+2, done at cycle 2**ADDR_W+3 (35 for default).
REQ-024 busy SHALL be high from the first READ cycle through the last write cycle, and low in DONE and IDLE.
REQ-025 Sum computed at DATA_W+1 bits; carry-out SHALL set ovf.
REQ-026 incr=0 SHALL perform a full sweep writing words back unchanged.
REQ-027 Outside READ/write cycles, port_en_0, wr_en and port_en_1 SHALL be 0.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE and drive all outputs, counters and pipeline registers to 0.
REQ-029 Reset mid-sweep SHALL abort without done; memory is left partially updated; no further writes issue.

Configuration
REQ-030 Macro RMW_SATURATE_EN defined: on carry-out, data_in SHALL be 2**DATA_W-1.
REQ-031 Macro undefined: data_in SHALL be the low DATA_W bits of the sum (wrap); ovf behaviour identical in both builds.

Structure
REQ-032 Package mem_rmw_pkg holds the FSM state enum and default DATA_W/ADDR_W constants.
REQ-033 No sub-module; the adder/saturation stage is inline; dual_port_memory is instantiated only in the bench.

Verification
REQ-034 Preload addr i = i+1, incr=10, start -> addr i holds i+11 for all 32 words; done in cycle 35; ovf=0.
REQ-035 addr 0 = 0xFFFF_FFF8, incr=10 -> addr 0 = 0xFFFF_FFFF with RMW_SATURATE_EN, 0x0000_0002 without; ovf=1.
REQ-036 start pulsed again at cycle 10 of a sweep -> ignored; exactly 32 writes, one done.
REQ-037 rst_n=0 at cycle 12 -> next cycle all outputs 0; addrs 0..8 updated, 9..31 unchanged; no done.
REQ-038 start in cycle after done, incr=10 again -> second sweep accepted; addr i holds i+21; ovf cleared then 0.
REQ-039 incr=0 sweep -> memory contents unchanged; busy high for cycles 1..34 exactly.

Source files
------------

// File: rtl/mem_rmw_pkg.sv
// Shared types and default sizing for the read-modify-write memory sweeper.
package mem_rmw_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_rmw_sweeper.sv
// Sweeps a dual-port memory adding a captured increment to every word.
// Optional macro RMW_SATURATE_EN clamps overflowing sums to all-ones instead of wrapping.
module mem_rmw_sweeper
  import mem_rmw_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] incr,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              wr_en,
  output logic              port_en_0,
  output logic [ADDR_W-1:0] addr_in_0,
  output logic [DATA_W-1:0] data_in,
  output logic              port_en_1,
  output logic [ADDR_W-1:0] addr_in_1,
  input  logic [DATA_W-1:0] data_out_1
);

  state_e              state;
  logic [DATA_W-1:0]   incr_q;
  logic                drain_cnt;
  logic                rd_vld_q;   // a read was presented last cycle; its data is on data_out_1 now
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   wr_data;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    sum = {1'b0, data_out_1} + {1'b0, incr_q};
`ifdef RMW_SATURATE_EN
    wr_data = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
    wr_data = sum[DATA_W-1:0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      incr_q    <= '0;
      drain_cnt <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      wr_en     <= 1'b0;
      port_en_0 <= 1'b0;
      addr_in_0 <= '0;
      data_in   <= '0;
      port_en_1 <= 1'b0;
      addr_in_1 <= '0;
    end else begin
      done <= 1'b0;

      // Write stage: trails the read it belongs to by two cycles, so it never hits the live read address.
      rd_vld_q  <= port_en_1;
      rd_addr_q <= addr_in_1;
      wr_en     <= rd_vld_q;
      port_en_0 <= rd_vld_q;
      if (rd_vld_q) begin
        addr_in_0 <= rd_addr_q;
        data_in   <= wr_data;
        if (sum[DATA_W]) ovf <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_READ;
            incr_q    <= incr;
            ovf       <= 1'b0;
            addr_in_1 <= '0;
            port_en_1 <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_READ: begin
          if (addr_in_1 == {ADDR_W{1'b1}}) begin
            port_en_1 <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            addr_in_1 <= addr_in_1 + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          // Two cycles let the last two reads complete their writes.
          if (drain_cnt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rmw_sweeper.sv
// Self-checking bench for mem_rmw_sweeper: behavioural dual-port memory plus an arithmetic reference model.
module tb_mem_rmw_sweeper;
  import mem_rmw_pkg::*;

  localparam int DW    = DEF_DATA_W;
  localparam int AW    = DEF_ADDR_W;
  localparam int DEPTH = 1 << AW;
  localparam logic [63:0] MAX_WORD = (64'd1 << DW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [DW-1:0] incr;
  logic          busy, done, ovf, wr_en, port_en_0, port_en_1;
  logic [AW-1:0] addr_in_0, addr_in_1;
  logic [DW-1:0] data_in, data_out_1;

  always #5 clk = ~clk;

  mem_rmw_sweeper #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .incr(incr),
    .busy(busy), .done(done), .ovf(ovf),
    .wr_en(wr_en), .port_en_0(port_en_0), .addr_in_0(addr_in_0), .data_in(data_in),
    .port_en_1(port_en_1), .addr_in_1(addr_in_1), .data_out_1(data_out_1)
  );

  // Behavioural dual-port memory with a bench-side load port for preloading.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (port_en_0 && wr_en) mem[addr_in_0] <= data_in;
    if (port_en_1) rd_q <= mem[addr_in_1];
  end
  assign data_out_1 = rd_q;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] pre     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];

  int   r_done_cyc, r_n_done, r_n_wr, r_bad, r_bad_data, r_busy_cnt, r_first_bad;
  logic r_ovf_c1, r_ovf_end, r_zero_ok;

  // Reference: word plus increment in wide arithmetic, then wrap or clamp.
  function automatic logic [DW-1:0] rmw(input logic [DW-1:0] w, input logic [DW-1:0] inc);
    logic [63:0] s;
    s = 64'(w) + 64'(inc);
`ifdef RMW_SATURATE_EN
    if (s > MAX_WORD) return {DW{1'b1}};
`endif
    return s[DW-1:0];
  endfunction

  function automatic bit carries(input logic [DW-1:0] w, input logic [DW-1:0] inc);
    return (64'(w) + 64'(inc)) > MAX_WORD;
  endfunction

  function automatic int mem_errors();
    int e = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) e++;
    return e;
  endfunction

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = pre[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Starts a sweep and watches n_cyc cycles after the accepting edge (cycle 1 = first cycle after it).
  // restart_cyc > 0 pulses start during that cycle; reset_cyc > 0 holds rst_n low during that cycle,
  // so the reset is sampled at its closing edge and the following cycle must be all-zero.
  task automatic run_sweep(input logic [DW-1:0] inc, input int n_cyc, input int restart_cyc,
                           input int reset_cyc);
    bit live, exp_rd, exp_wr, exp_busy, exp_done;
    r_done_cyc = -1; r_n_done = 0; r_n_wr = 0; r_bad = 0; r_bad_data = 0; r_busy_cnt = 0;
    r_first_bad = -1; r_ovf_c1 = 1'bx; r_ovf_end = 1'bx; r_zero_ok = 1'b0;
    @(negedge clk);
    start = 1'b1; incr = inc;
    for (int cyc = 1; cyc <= n_cyc; cyc++) begin
      @(negedge clk);
      live     = (reset_cyc == 0) || (cyc <= reset_cyc);
      exp_rd   = live && cyc <= DEPTH;
      exp_wr   = live && cyc >= 3 && cyc <= DEPTH + 2;
      exp_busy = live && cyc <= DEPTH + 2;
      exp_done = live && cyc == DEPTH + 3;
      if (port_en_1 !== exp_rd || (exp_rd && addr_in_1 !== AW'(cyc - 1)) ||
          port_en_0 !== exp_wr || wr_en !== exp_wr || (exp_wr && addr_in_0 !== AW'(cyc - 3)) ||
          busy !== exp_busy || done !== exp_done) begin
        r_bad++;
        if (r_first_bad < 0) r_first_bad = cyc;
      end
      if (exp_wr && wr_en === 1'b1 && data_in !== rmw(pre[addr_in_0], inc)) r_bad_data++;
      if (done === 1'b1) begin r_n_done++; r_done_cyc = cyc; end
      if (wr_en === 1'b1 && port_en_0 === 1'b1) r_n_wr++;
      if (busy === 1'b1) r_busy_cnt++;
      if (cyc == 1) r_ovf_c1 = ovf;
      if (reset_cyc > 0 && cyc == reset_cyc + 1)
        r_zero_ok = ({busy, done, ovf, wr_en, port_en_0, port_en_1, addr_in_0, addr_in_1, data_in} === '0);
      r_ovf_end = ovf;
      start = (cyc == restart_cyc);
      rst_n = !(cyc == reset_cyc);
      if (cyc == 1) incr = $urandom;  // must not matter once captured
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; incr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, ovf, wr_en, port_en_0, port_en_1, addr_in_0, addr_in_1, data_in} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b wr=%b pe0=%b pe1=%b a0=%h a1=%h d=%h, want all 0",
               busy, done, ovf, wr_en, port_en_0, port_en_1, addr_in_0, addr_in_1, data_in);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, wr_en, port_en_0, port_en_1} !== '0)
      $display("FAIL idle_quiet: got busy=%b done=%b wr=%b pe0=%b pe1=%b, want all 0",
               busy, done, wr_en, port_en_0, port_en_1);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] want0;
    for (int i = 0; i < DEPTH; i++) pre[i] = $urandom & 32'h0FFF_FFFF;
    pre[0] = 32'hFFFF_FFF8;
    preload();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = rmw(pre[i], 32'd10);
    run_sweep(32'd10, 40, 0, 0);
`ifdef RMW_SATURATE_EN
    want0 = 32'hFFFF_FFFF;
`else
    want0 = 32'h0000_0002;
`endif
    n_checks++;
    if (mem[0] !== want0) $display("FAIL ovf_word0: got %h, want %h", mem[0], want0);
    else n_pass++;
    n_checks++;
    if (r_ovf_end !== 1'b1) $display("FAIL ovf_flag: got %b, want 1", r_ovf_end);
    else n_pass++;
    n_checks++;
    if (mem_errors() !== 0) $display("FAIL ovf_mem: got %0d bad words, want 0", mem_errors());
    else n_pass++;
  endtask

  task automatic test_basic();
    for (int i = 0; i < DEPTH; i++) pre[i] = DW'(i + 1);
    preload();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = DW'(i + 11);
    run_sweep(32'd10, 40, 0, 0);
    n_checks++;
    if (r_bad !== 0) $display("FAIL basic_timing: got %0d bad cycles (first %0d), want 0", r_bad, r_first_bad);
    else n_pass++;
    n_checks++;
    if (r_bad_data !== 0) $display("FAIL basic_wdata: got %0d bad writes, want 0", r_bad_data);
    else n_pass++;
    n_checks++;
    if (r_done_cyc !== DEPTH + 3) $display("FAIL basic_done_cycle: got %0d, want %0d", r_done_cyc, DEPTH + 3);
    else n_pass++;
    n_checks++;
    if (r_n_wr !== DEPTH) $display("FAIL basic_writes: got %0d, want %0d", r_n_wr, DEPTH);
    else n_pass++;
    n_checks++;
    if (r_ovf_c1 !== 1'b0 || r_ovf_end !== 1'b0)
      $display("FAIL basic_ovf_cleared: got c1=%b end=%b, want 0/0", r_ovf_c1, r_ovf_end);
    else n_pass++;
    n_checks++;
    if (mem_errors() !== 0) $display("FAIL basic_mem: got %0d bad words, want 0", mem_errors());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) pre[i] = DW'(i + 1);
    preload();
    run_sweep(32'd10, DEPTH + 3, 0, 0);  // returns in the done cycle
    n_checks++;
    if (r_n_done !== 1 || r_done_cyc !== DEPTH + 3)
      $display("FAIL b2b_first_done: got %0d pulses at %0d, want 1 at %0d", r_n_done, r_done_cyc, DEPTH + 3);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) pre[i] = DW'(i + 11);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = DW'(i + 21);
    run_sweep(32'd10, 40, 0, 0);  // start lands in the cycle right after done
    n_checks++;
    if (r_bad !== 0 || r_bad_data !== 0 || r_n_done !== 1)
      $display("FAIL b2b_second: got bad=%0d bad_data=%0d done=%0d, want 0/0/1", r_bad, r_bad_data, r_n_done);
    else n_pass++;
    n_checks++;
    if (r_ovf_c1 !== 1'b0 || r_ovf_end !== 1'b0)
      $display("FAIL b2b_ovf: got c1=%b end=%b, want 0/0", r_ovf_c1, r_ovf_end);
    else n_pass++;
    n_checks++;
    if (mem_errors() !== 0) $display("FAIL b2b_mem: got %0d bad words, want 0", mem_errors());
    else n_pass++;
  endtask

  task automatic test_restart_ignored();
    logic [DW-1:0] inc;
    inc = $urandom;
    for (int i = 0; i < DEPTH; i++) pre[i] = $urandom;
    preload();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = rmw(pre[i], inc);
    run_sweep(inc, 45, 10, 0);
    n_checks++;
    if (r_n_wr !== DEPTH || r_n_done !== 1 || r_bad !== 0)
      $display("FAIL restart_ignored: got writes=%0d done=%0d bad=%0d, want %0d/1/0",
               r_n_wr, r_n_done, r_bad, DEPTH);
    else n_pass++;
    n_checks++;
    if (mem_errors() !== 0) $display("FAIL restart_mem: got %0d bad words, want 0", mem_errors());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [DW-1:0] inc;
    bit any_carry;
    for (int t = 0; t < 3; t++) begin
      inc = (t == 0) ? ($urandom & 32'h0000_FFFF) : $urandom;
      any_carry = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pre[i] = $urandom;
        exp_mem[i] = rmw(pre[i], inc);
        if (carries(pre[i], inc)) any_carry = 1'b1;
      end
      preload();
      run_sweep(inc, 40, 0, 0);
      n_checks++;
      if (r_bad !== 0 || r_bad_data !== 0)
        $display("FAIL random%0d_stream: got bad=%0d bad_data=%0d, want 0/0", t, r_bad, r_bad_data);
      else n_pass++;
      n_checks++;
      if (r_ovf_end !== any_carry) $display("FAIL random%0d_ovf: got %b, want %b", t, r_ovf_end, any_carry);
      else n_pass++;
      n_checks++;
      if (mem_errors() !== 0) $display("FAIL random%0d_mem: got %0d bad words, want 0", t, mem_errors());
      else n_pass++;
    end
  endtask

  task automatic test_zero_incr();
    for (int i = 0; i < DEPTH; i++) begin
      pre[i] = $urandom;
      exp_mem[i] = pre[i];
    end
    preload();
    run_sweep('0, 40, 0, 0);
    n_checks++;
    if (r_busy_cnt !== DEPTH + 2 || r_bad !== 0)
      $display("FAIL zero_busy: got busy_cycles=%0d bad=%0d, want %0d/0", r_busy_cnt, r_bad, DEPTH + 2);
    else n_pass++;
    n_checks++;
    if (mem_errors() !== 0 || r_n_wr !== DEPTH)
      $display("FAIL zero_mem: got %0d bad words, %0d writes, want 0/%0d", mem_errors(), r_n_wr, DEPTH);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] inc;
    localparam int RST_CYC = 11;  // sampled at the edge opening cycle 12
    inc = $urandom;
    for (int i = 0; i < DEPTH; i++) begin
      pre[i] = $urandom;
      exp_mem[i] = (i <= RST_CYC - 3) ? rmw(pre[i], inc) : pre[i];
    end
    preload();
    run_sweep(inc, 40, 0, RST_CYC);
    n_checks++;
    if (r_zero_ok !== 1'b1) $display("FAIL midrst_outputs: got nonzero outputs after reset, want all 0");
    else n_pass++;
    n_checks++;
    if (r_n_done !== 0 || r_n_wr !== RST_CYC - 2 || r_bad !== 0)
      $display("FAIL midrst_abort: got done=%0d writes=%0d bad=%0d, want 0/%0d/0",
               r_n_done, r_n_wr, r_bad, RST_CYC - 2);
    else n_pass++;
    n_checks++;
    if (mem_errors() !== 0) $display("FAIL midrst_mem: got %0d bad words, want 0", mem_errors());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_basic();
    test_back_to_back();
    test_restart_ignored();
    test_random();
    test_zero_incr();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
